// File: rtl/led_pwm_driver.sv
// Six-channel LED PWM driver with an active-low output stage.
// A prescaler sets the PWM step rate and an 8-bit phase counter sweeps each frame.
// Duty writes go through a single pending slot and only take effect on a frame
// boundary, so a channel never glitches mid-frame. Channel 5 can breathe on its own.

module led_pwm_driver #(
    parameter int unsigned PRESCALE = 234
) (
    input  logic       clk_60mhz,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_chan,
    input  logic [7:0] wr_duty,
    input  logic       breathe_en,
    output logic       frame_start,
    output logic [5:0] led
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc_cnt;
    logic [7:0]  phase;
    logic [7:0]  duty [0:5];
    logic [7:0]  duty_next [0:5];
    logic        pending;
    logic [2:0]  pend_chan;
    logic [7:0]  pend_duty;
    logic        dir_up;
    logic        dir_next;
    logic [7:0]  ramp_duty;
    logic        ramp_dir;
    logic        step_tick;
    logic        frame_tick;
    logic        wr_accept;
    logic        pend_is_ch5;

    assign step_tick   = (presc_cnt == PRESC_LAST);
    assign frame_tick  = step_tick && (phase == 8'hFF);
    assign frame_start = frame_tick;
    assign wr_ready    = ~pending;
    assign wr_accept   = wr_valid && ~pending;
    assign pend_is_ch5 = pending && (pend_chan == 3'd5);

    // Prescaler and phase counter: phase advances once per PRESCALE cycles.
    always_ff @(posedge clk_60mhz or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            phase     <= '0;
        end else if (step_tick) begin
            presc_cnt <= '0;
            phase     <= phase + 8'd1;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end

    // Next triangle-ramp value for channel 5; turns around at the ends instead of wrapping.
    always_comb begin
        ramp_duty = duty[5];
        ramp_dir  = dir_up;
        if (dir_up) begin
            if (duty[5] == 8'hFF) begin
                ramp_duty = 8'hFE;
                ramp_dir  = 1'b0;
            end else begin
                ramp_duty = duty[5] + 8'd1;
                if (duty[5] == 8'hFE) ramp_dir = 1'b0;
            end
        end else begin
            if (duty[5] == 8'h00) begin
                ramp_duty = 8'h01;
                ramp_dir  = 1'b1;
            end else begin
                ramp_duty = duty[5] - 8'd1;
                if (duty[5] == 8'h01) ramp_dir = 1'b1;
            end
        end
    end

    // Frame-boundary update of the active duties; a pending write to ch5 beats the ramp step.
    always_comb begin
        for (int i = 0; i < 6; i++) duty_next[i] = duty[i];
        dir_next = dir_up;
        if (frame_tick) begin
            for (int i = 0; i < 6; i++) begin
                if (pending && (pend_chan == 3'(i))) duty_next[i] = pend_duty;
            end
            if (breathe_en && !pend_is_ch5) begin
                duty_next[5] = ramp_duty;
                dir_next     = ramp_dir;
            end
        end
    end

    // Active duty registers and breathing direction.
    always_ff @(posedge clk_60mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) duty[i] <= '0;
            dir_up <= 1'b1;
        end else begin
            for (int i = 0; i < 6; i++) duty[i] <= duty_next[i];
            dir_up <= dir_next;
        end
    end

    // Single pending write slot; writes to channels 6/7 are accepted but dropped.
    always_ff @(posedge clk_60mhz or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            pend_chan <= '0;
            pend_duty <= '0;
        end else if (wr_accept) begin
            if (wr_chan <= 3'd5) begin
                pending   <= 1'b1;
                pend_chan <= wr_chan;
                pend_duty <= wr_duty;
            end
        end else if (frame_tick) begin
            pending <= 1'b0;
        end
    end

    // Registered active-low LED outputs, lit while phase is below the duty.
    always_ff @(posedge clk_60mhz or negedge rst_n) begin
        if (!rst_n) begin
            led <= 6'b111111;
        end else begin
            for (int i = 0; i < 6; i++) led[i] <= ~(phase < duty[i]);
        end
    end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver: one instance with PRESCALE=1 and one with
// PRESCALE=3, checked against a frame-arithmetic reference model and explicit patterns.

module tb_led_pwm_driver;

    logic       clk_60mhz = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_valid3 = 1'b0;
    logic [2:0] wr_chan = '0;
    logic [7:0] wr_duty = '0;
    logic       breathe_en = 1'b0;
    logic       wr_ready, frame_start;
    logic [5:0] led;
    logic       wr_ready3, frame_start3;
    logic [5:0] led3;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 for PRESCALE=1 and index 1 for PRESCALE=3.
    int unsigned m_n [2];
    logic [7:0]  m_duty [2][6];
    bit          m_pend [2];
    logic [2:0]  m_pch [2];
    logic [7:0]  m_pdu [2];
    bit          m_dir [2];
    logic [5:0]  m_led [2];

    always #5 clk_60mhz = ~clk_60mhz;

    led_pwm_driver #(.PRESCALE(1)) dut (
        .clk_60mhz(clk_60mhz), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_chan(wr_chan), .wr_duty(wr_duty), .breathe_en(breathe_en),
        .frame_start(frame_start), .led(led)
    );

    led_pwm_driver #(.PRESCALE(3)) dut3 (
        .clk_60mhz(clk_60mhz), .rst_n(rst_n), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
        .wr_chan(wr_chan), .wr_duty(wr_duty), .breathe_en(breathe_en),
        .frame_start(frame_start3), .led(led3)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0;
            for (int i = 0; i < 6; i++) m_duty[k][i] = 8'd0;
            m_pend[k] = 1'b0;
            m_pch[k]  = 3'd0;
            m_pdu[k]  = 8'd0;
            m_dir[k]  = 1'b1;
            m_led[k]  = 6'b111111;
        end
    endtask

    // One clock edge of the model: cycle n since reset sits at phase (n/P)%256 and
    // is a frame boundary when n%(256P) is the last cycle of the frame.
    task automatic model_step(input int k, input logic valid);
        int unsigned p;
        int unsigned ph;
        bit bnd, acc, skip;
        int d;
        if (rst_n !== 1'b1) return;
        p   = (k == 0) ? 1 : 3;
        ph  = (m_n[k] / p) % 256;
        bnd = ((m_n[k] % (256 * p)) == (256 * p - 1));
        acc = (valid === 1'b1) && !m_pend[k];
        for (int i = 0; i < 6; i++) m_led[k][i] = !(ph < m_duty[k][i]);
        if (bnd) begin
            skip = 1'b0;
            if (m_pend[k]) begin
                m_duty[k][m_pch[k]] = m_pdu[k];
                skip = (m_pch[k] == 3'd5);
                m_pend[k] = 1'b0;
            end
            if (breathe_en && !skip) begin
                d = int'(m_duty[k][5]);
                d = m_dir[k] ? d + 1 : d - 1;
                if (d > 255) begin
                    d = 254;
                    m_dir[k] = 1'b0;
                end else if (d < 0) begin
                    d = 1;
                    m_dir[k] = 1'b1;
                end else if (d == 255) begin
                    m_dir[k] = 1'b0;
                end else if (d == 0) begin
                    m_dir[k] = 1'b1;
                end
                m_duty[k][5] = 8'(d);
            end
        end
        if (acc && (wr_chan <= 3'd5)) begin
            m_pend[k] = 1'b1;
            m_pch[k]  = wr_chan;
            m_pdu[k]  = wr_duty;
        end
        m_n[k]++;
    endtask

    task automatic tick();
        @(posedge clk_60mhz);
        model_step(0, wr_valid);
        model_step(1, wr_valid3);
        @(negedge clk_60mhz);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_valid = 1'b0;
        wr_valid3 = 1'b0;
        model_reset();
        @(negedge clk_60mhz);
        rst_n = 1'b1;
    endtask

    task automatic send_write(input logic [2:0] ch, input logic [7:0] d);
        bit done = 1'b0;
        wr_valid = 1'b1;
        wr_chan  = ch;
        wr_duty  = d;
        for (int c = 0; c < 1000 && !done; c++) begin
            done = (wr_ready === 1'b1);
            tick();
        end
        wr_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL write_accept ch=%0d accepted=%0d required=1", ch, done);
        end
    endtask

    task automatic wait_boundary();
        bit seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            if (frame_start === 1'b1) seen = 1'b1;
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL frame_wait seen=%0d required=1", seen);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        model_reset();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({led, wr_ready, frame_start} !== 8'b1111_1110) begin
            errors++;
            $display("[TB] FAIL reset_dut got=%b required=11111110", {led, wr_ready, frame_start});
        end
        checks++;
        if ({led3, wr_ready3, frame_start3} !== 8'b1111_1110) begin
            errors++;
            $display("[TB] FAIL reset_dut3 got=%b required=11111110", {led3, wr_ready3, frame_start3});
        end
        @(negedge clk_60mhz);
        rst_n = 1'b1;
    endtask

    task automatic test_duty_write();
        bit found = 1'b0;
        logic exp;
        wr_valid = 1'b1;
        wr_chan  = 3'd0;
        wr_duty  = 8'd64;
        tick();
        wr_valid = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            if (frame_start === 1'b1) found = 1'b1;
            checks++;
            if (wr_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pending_ready c=%0d got=%b required=0", c, wr_ready);
            end
            if (!found) tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL duty_boundary found=%0d required=1", found);
        end
        tick();
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL commit_ready got=%b required=1", wr_ready);
        end
        for (int j = 0; j < 512; j++) begin
            tick();
            exp = ((j % 256) < 64) ? 1'b0 : 1'b1;
            checks++;
            if (led[0] !== exp) begin
                errors++;
                $display("[TB] FAIL duty64_led0 j=%0d got=%b required=%b", j, led[0], exp);
            end
        end
    endtask

    task automatic test_extremes();
        logic [2:0] exp;
        send_write(3'd1, 8'd128);
        send_write(3'd1, 8'd0);
        send_write(3'd2, 8'd255);
        wait_boundary();
        for (int j = 0; j < 512; j++) begin
            tick();
            exp[0] = ((j % 256) < 64) ? 1'b0 : 1'b1;
            exp[1] = 1'b1;
            exp[2] = ((j % 256) == 255) ? 1'b1 : 1'b0;
            checks++;
            if (led[2:0] !== exp) begin
                errors++;
                $display("[TB] FAIL extremes_led j=%0d got=%b required=%b", j, led[2:0], exp);
            end
        end
    endtask

    task automatic test_invalid_chan();
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL invalid_pre_ready got=%b required=1", wr_ready);
        end
        for (int ch = 6; ch < 8; ch++) begin
            wr_valid = 1'b1;
            wr_chan  = 3'(ch);
            wr_duty  = 8'd77;
            tick();
            wr_valid = 1'b0;
            checks++;
            if (wr_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL invalid_ready ch=%0d got=%b required=1", ch, wr_ready);
            end
        end
        for (int c = 0; c < 600; c++) begin
            tick();
            checks++;
            if ({led, wr_ready, frame_start} !== {m_led[0], !m_pend[0], ((m_n[0] % 256) == 255)}) begin
                errors++;
                $display("[TB] FAIL invalid_leds c=%0d got=%b required=%b", c,
                         {led, wr_ready, frame_start}, {m_led[0], !m_pend[0], ((m_n[0] % 256) == 255)});
            end
        end
    endtask

    task automatic test_reset_midframe();
        wait_boundary();
        repeat (10) tick();
        checks++;
        if (led !== 6'b111010) begin
            errors++;
            $display("[TB] FAIL midframe_pre_led got=%b required=111010", led);
        end
        wr_valid = 1'b1;
        wr_chan  = 3'd3;
        wr_duty  = 8'd200;
        tick();
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midframe_pending got=%b required=0", wr_ready);
        end
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({led, wr_ready, frame_start} !== 8'b1111_1110) begin
            errors++;
            $display("[TB] FAIL midframe_reset got=%b required=11111110", {led, wr_ready, frame_start});
        end
        model_reset();
        @(negedge clk_60mhz);
        rst_n = 1'b1;
        for (int c = 0; c < 600; c++) begin
            tick();
            checks++;
            if ({led, wr_ready, frame_start} !== {m_led[0], !m_pend[0], ((m_n[0] % 256) == 255)}) begin
                errors++;
                $display("[TB] FAIL post_reset c=%0d got=%b required=%b", c,
                         {led, wr_ready, frame_start}, {m_led[0], !m_pend[0], ((m_n[0] % 256) == 255)});
            end
        end
    endtask

    task automatic test_random();
        bit efs0, efs3;
        for (int c = 0; c < 4000; c++) begin
            wr_valid  = ($urandom_range(0, 3) == 0);
            wr_valid3 = ($urandom_range(0, 3) == 0);
            wr_chan   = 3'($urandom_range(0, 7));
            wr_duty   = (wr_chan == 3'd5) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 299) == 0) breathe_en = ~breathe_en;
            tick();
            efs0 = ((m_n[0] % 256) == 255);
            efs3 = ((m_n[1] % 768) == 767);
            checks++;
            if ({led, wr_ready, frame_start} !== {m_led[0], !m_pend[0], efs0}) begin
                errors++;
                $display("[TB] FAIL random_p1 c=%0d got=%b required=%b", c,
                         {led, wr_ready, frame_start}, {m_led[0], !m_pend[0], efs0});
            end
            checks++;
            if ({led3, wr_ready3, frame_start3} !== {m_led[1], !m_pend[1], efs3}) begin
                errors++;
                $display("[TB] FAIL random_p3 c=%0d got=%b required=%b", c,
                         {led3, wr_ready3, frame_start3}, {m_led[1], !m_pend[1], efs3});
            end
        end
        wr_valid   = 1'b0;
        wr_valid3  = 1'b0;
        breathe_en = 1'b0;
    endtask

    task automatic test_breathing();
        int exp_tab [24] = '{1, 2, 3, 4, 5, 250, 251, 252, 253, 254, 255, 254,
                             253, 3, 2, 1, 0, 1, 2, 99, 100, 10, 11, 12};
        int wr_tab [24]  = '{-1, -1, -1, -1, 250, -1, -1, -1, -1, -1, -1, -1,
                             3, -1, -1, -1, -1, -1, 99, -1, 10, -1, -1, -1};
        int low;
        bit found = 1'b0;
        breathe_en = 1'b1;
        do_reset();
        for (int c = 0; c < 1000 && !found; c++) begin
            if (frame_start === 1'b1) found = 1'b1;
            else tick();
        end
        for (int f = 0; f < 24; f++) begin
            checks++;
            if (frame_start !== 1'b1) begin
                errors++;
                $display("[TB] FAIL breathe_frame f=%0d got=%b required=1", f, frame_start);
            end
            low = 0;
            for (int j = 0; j < 256; j++) begin
                if (j == 8 && wr_tab[f] >= 0) begin
                    wr_valid = 1'b1;
                    wr_chan  = 3'd5;
                    wr_duty  = 8'(wr_tab[f]);
                end
                if (j == 9) wr_valid = 1'b0;
                tick();
                if (led[5] === 1'b0) low++;
            end
            checks++;
            if (low !== exp_tab[f]) begin
                errors++;
                $display("[TB] FAIL breathe_duty f=%0d got=%0d required=%0d", f, low, exp_tab[f]);
            end
        end
        breathe_en = 1'b0;
    endtask

    task automatic test_prescale();
        int cnt, low, rdy_bad;
        bit found = 1'b0;
        do_reset();
        for (int c = 0; c < 2000 && !found; c++) begin
            if (frame_start3 === 1'b1) found = 1'b1;
            else tick();
        end
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (frame_start3 !== 1'b1 && cnt < 2000);
        checks++;
        if (cnt !== 768) begin
            errors++;
            $display("[TB] FAIL p3_period got=%0d required=768", cnt);
        end
        wr_valid3 = 1'b1;
        wr_chan   = 3'd0;
        wr_duty   = 8'd128;
        tick();
        wr_valid3 = 1'b0;
        checks++;
        if (wr_ready3 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL p3_boundary_accept got=%b required=0", wr_ready3);
        end
        cnt = 1;
        low = (led3[0] === 1'b0) ? 1 : 0;
        rdy_bad = 0;
        while (frame_start3 !== 1'b1 && cnt < 2000) begin
            tick();
            cnt++;
            if (led3[0] === 1'b0) low++;
            if (frame_start3 !== 1'b1 && wr_ready3 !== 1'b0) rdy_bad++;
        end
        checks++;
        if ({cnt, low, rdy_bad} !== {32'd768, 32'd0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL p3_hold_frame cycles=%0d lows=%0d ready_errs=%0d required=768/0/0",
                     cnt, low, rdy_bad);
        end
        low = 0;
        for (int j = 0; j < 768; j++) begin
            tick();
            if (led3[0] === 1'b0) low++;
        end
        checks++;
        if (low !== 384) begin
            errors++;
            $display("[TB] FAIL p3_commit_duty got=%0d required=384", low);
        end
        checks++;
        if ({frame_start3, wr_ready3} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL p3_end_state got=%b required=11", {frame_start3, wr_ready3});
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_duty_write();
        test_extremes();
        test_invalid_chan();
        test_reset_midframe();
        test_random();
        test_breathing();
        test_prescale();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
